// File: rtl/exception_sequencer.sv
// CP0 exception sequencer: arbitrates sync exceptions and interrupts,
// flushes, redirects to the handler and blocks re-entry until eret.
module exception_sequencer #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] HANDLER_PC   = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exc_syscall,
  input  logic        exc_ov,
  input  logic        exc_ri,
  input  logic [31:0] exc_pc,
  input  logic [3:0]  irq,
  input  logic [3:0]  irq_mask,
  input  logic        is_eret,
  output logic        exp_en,
  output logic [2:0]  exp_src,
  output logic [31:0] epc_out,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        in_service,
  output logic [3:0]  pending,
  output logic        exc_dropped
);

  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, TAKE, FLUSH, REDIRECT, SERVICE, RETURN
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  irq_q_q, irq_q_d;
  logic [3:0]  pending_q, pending_d;
  logic        exp_en_q, exp_en_d;
  logic [2:0]  exp_src_q, exp_src_d;
  logic [31:0] epc_q, epc_d;
  logic        flush_q, flush_d;
  logic        redirect_q, redirect_d;
  logic [31:0] rpc_q, rpc_d;
  logic        insvc_q, insvc_d;
  logic        drop_q, drop_d;

  logic [3:0]  irq_rise;
  logic [3:0]  cand;
  logic        sync_any;
  logic [2:0]  sel_code;

  assign irq_rise = irq & ~irq_q_q;
  assign cand     = pending_q & irq_mask;
  assign sync_any = exc_ri | exc_ov | exc_syscall;

  always_comb begin
    sel_code = 3'b000;
    if (exc_ri)           sel_code = 3'b011;
    else if (exc_ov)      sel_code = 3'b010;
    else if (exc_syscall) sel_code = 3'b001;
    else if (cand[0])     sel_code = 3'b100;
    else if (cand[1])     sel_code = 3'b101;
    else if (cand[2])     sel_code = 3'b110;
    else if (cand[3])     sel_code = 3'b111;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    irq_q_d    = irq;
    pending_d  = pending_q | irq_rise;
    exp_en_d   = 1'b0;
    exp_src_d  = 3'b000;
    epc_d      = epc_q;
    flush_d    = 1'b0;
    redirect_d = 1'b0;
    rpc_d      = rpc_q;
    insvc_d    = 1'b0;
    drop_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!stall && (sync_any || |cand)) begin
          state_d   = TAKE;
          exp_en_d  = 1'b1;
          exp_src_d = sel_code;
          epc_d     = exc_pc;
          flush_d   = 1'b1;
        end
      end
      TAKE: begin
        // a fresh edge on the taken line this cycle keeps its bit set
        if (exp_src_q[2])
          pending_d = (pending_q & ~(4'b0001 << exp_src_q[1:0])) | irq_rise;
        cnt_d   = CW'(FLUSH_CYCLES);
        state_d = FLUSH;
        flush_d = 1'b1;
      end
      FLUSH: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d    = REDIRECT;
          redirect_d = 1'b1;
          rpc_d      = HANDLER_PC;
        end else begin
          flush_d = 1'b1;
        end
      end
      REDIRECT: begin
        state_d = SERVICE;
        insvc_d = 1'b1;
      end
      SERVICE: begin
        insvc_d = 1'b1;
        drop_d  = sync_any;
        if (is_eret) begin
          state_d    = RETURN;
          flush_d    = 1'b1;
          redirect_d = 1'b1;
          rpc_d      = epc_q;
        end
      end
      RETURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      irq_q_q    <= '0;
      pending_q  <= '0;
      exp_en_q   <= 1'b0;
      exp_src_q  <= '0;
      epc_q      <= '0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      insvc_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irq_q_q    <= irq_q_d;
      pending_q  <= pending_d;
      exp_en_q   <= exp_en_d;
      exp_src_q  <= exp_src_d;
      epc_q      <= epc_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      insvc_q    <= insvc_d;
      drop_q     <= drop_d;
    end
  end

  assign exp_en      = exp_en_q;
  assign exp_src     = exp_src_q;
  assign epc_out     = epc_q;
  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;
  assign in_service  = insvc_q;
  assign pending     = pending_q;
  assign exc_dropped = drop_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer.
// Inputs change #1 after posedge; outputs checked at the same point.
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        exc_syscall, exc_ov, exc_ri;
  logic [31:0] exc_pc;
  logic [3:0]  irq, irq_mask;
  logic        is_eret;
  logic        exp_en;
  logic [2:0]  exp_src;
  logic [31:0] epc_out;
  logic        flush, redirect;
  logic [31:0] redirect_pc;
  logic        in_service;
  logic [3:0]  pending;
  logic        exc_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exception_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall),
    .exc_syscall(exc_syscall), .exc_ov(exc_ov), .exc_ri(exc_ri),
    .exc_pc(exc_pc), .irq(irq), .irq_mask(irq_mask),
    .is_eret(is_eret), .exp_en(exp_en), .exp_src(exp_src),
    .epc_out(epc_out), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .in_service(in_service),
    .pending(pending), .exc_dropped(exc_dropped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    exc_syscall = 1'b0; exc_ov = 1'b0; exc_ri = 1'b0;
    exc_pc = 32'h0; irq = 4'h0; irq_mask = 4'hF; is_eret = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_exp_en", 32'(exp_en), 32'd0);
    chk("rst_exp_src", 32'(exp_src), 32'd0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_insvc", 32'(in_service), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_drop", 32'(exc_dropped), 32'd0);

    // syscall
    exc_syscall = 1'b1; exc_pc = 32'h0040_0020;
    tick();
    exc_syscall = 1'b0;
    chk("sys_exp_en", 32'(exp_en), 32'd1);
    chk("sys_exp_src", 32'(exp_src), 32'd1);
    chk("sys_epc", epc_out, 32'h0040_0020);
    chk("sys_flush0", 32'(flush), 32'd1);
    tick();
    chk("sys_exp_en_off", 32'(exp_en), 32'd0);
    chk("sys_src_off", 32'(exp_src), 32'd0);
    chk("sys_flush1", 32'(flush), 32'd1);
    tick();
    chk("sys_flush2", 32'(flush), 32'd1);
    chk("sys_noredir", 32'(redirect), 32'd0);
    tick();
    chk("sys_redir", 32'(redirect), 32'd1);
    chk("sys_rpc", redirect_pc, 32'h0040_0004);
    chk("sys_flush3", 32'(flush), 32'd0);
    tick();
    chk("sys_insvc", 32'(in_service), 32'd1);
    chk("sys_redir_off", 32'(redirect), 32'd0);

    // eret
    is_eret = 1'b1;
    tick();
    is_eret = 1'b0;
    chk("ret_redir", 32'(redirect), 32'd1);
    chk("ret_rpc", redirect_pc, 32'h0040_0020);
    chk("ret_flush", 32'(flush), 32'd1);
    chk("ret_insvc", 32'(in_service), 32'd1);
    tick();
    chk("idle_insvc", 32'(in_service), 32'd0);
    chk("idle_redir", 32'(redirect), 32'd0);
    chk("idle_flush", 32'(flush), 32'd0);

    // priority: ri beats ov and a fresh irq[1] edge
    exc_ov = 1'b1; exc_ri = 1'b1; irq = 4'b0010; exc_pc = 32'h0040_0100;
    tick();
    exc_ov = 1'b0; exc_ri = 1'b0;
    chk("pri_src", 32'(exp_src), 32'd3);
    chk("pri_pending", 32'(pending), 32'h2);
    tick();
    chk("pri_pend_kept", 32'(pending), 32'h2);
    tick(); tick(); tick();
    chk("pri_insvc", 32'(in_service), 32'd1);

    // drops in service
    exc_ri = 1'b1;
    tick();
    chk("drop1", 32'(exc_dropped), 32'd1);
    tick();
    exc_ri = 1'b0;
    chk("drop2", 32'(exc_dropped), 32'd1);
    tick();
    chk("drop_end", 32'(exc_dropped), 32'd0);
    chk("drop_no_exp", 32'(exp_en), 32'd0);
    chk("drop_still_svc", 32'(in_service), 32'd1);
    is_eret = 1'b1; exc_ov = 1'b1;
    tick();
    is_eret = 1'b0; exc_ov = 1'b0;
    chk("eret_ov_drop", 32'(exc_dropped), 32'd1);
    chk("eret_ov_redir", 32'(redirect), 32'd1);
    chk("eret_ov_rpc", redirect_pc, 32'h0040_0100);
    chk("eret_ov_noexp", 32'(exp_en), 32'd0);
    exc_pc = 32'h0040_0200;
    tick();
    chk("idle2_drop", 32'(exc_dropped), 32'd0);
    chk("idle2_noexp", 32'(exp_en), 32'd0);
    tick();
    irq = 4'b0000;
    chk("irq1_exp_en", 32'(exp_en), 32'd1);
    chk("irq1_src", 32'(exp_src), 32'd5);
    chk("irq1_epc", epc_out, 32'h0040_0200);
    tick();
    chk("irq1_cleared", 32'(pending), 32'h0);
    tick(); tick(); tick();
    chk("irq1_insvc", 32'(in_service), 32'd1);
    is_eret = 1'b1;
    tick();
    is_eret = 1'b0;
    tick();
    chk("irq1_done", 32'(in_service), 32'd0);

    // mask and stall
    irq_mask = 4'h0; irq = 4'b0100;
    tick();
    tick();
    chk("mask_noexp", 32'(exp_en), 32'd0);
    chk("mask_pending", 32'(pending), 32'h4);
    irq_mask = 4'b0100; stall = 1'b1;
    tick(); tick();
    chk("stall_noexp", 32'(exp_en), 32'd0);
    chk("stall_pending", 32'(pending), 32'h4);
    stall = 1'b0;
    tick();
    chk("irq2_src", 32'(exp_src), 32'd6);
    chk("irq2_exp_en", 32'(exp_en), 32'd1);
    irq = 4'b1100;
    tick();
    chk("flush_pending", 32'(pending), 32'h8);
    chk("flush_state", 32'(flush), 32'd1);

    // reset mid-flush
    rst = 1'b1; irq = 4'h0;
    tick();
    rst = 1'b0;
    chk("mrst_flush", 32'(flush), 32'd0);
    chk("mrst_redir", 32'(redirect), 32'd0);
    chk("mrst_pending", 32'(pending), 32'h0);
    chk("mrst_src", 32'(exp_src), 32'd0);
    chk("mrst_epc", epc_out, 32'h0);
    tick();
    chk("mrst_noredir", 32'(redirect), 32'd0);
    chk("mrst_noexp", 32'(exp_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
